pll_lock_supervisor: RTL and testbench

Parametrised supervisor that sits beside an iCE40 `SB_PLL40_CORE` wrapper in the HP2VGA clocking path and owns the PLL's reset, bypass and lock qualification.
- Sequences PLL reset and waits for a debounced, stable lock.
- Retries on lock timeout and declares a fault after a bounded number of retries.
- Releases `NUM_CHANNELS` downstream active-low resets in staggered order.
- Re-runs the whole sequence on lock loss or on a bypass-mode change.

---
 rtl/hp2vga_clk_pkg.sv | 24 ++
 rtl/cdc_sync2.sv | 25 ++
 rtl/pll_lock_supervisor.sv | 193 +++++++++++++++++++
 tb/tb_pll_lock_supervisor.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hp2vga_clk_pkg.sv
// rtl/hp2vga_clk_pkg.sv - shared state encoding and counter sizing for the HP2VGA clock supervisor
package hp2vga_clk_pkg;

    typedef enum logic [2:0] {
        ST_PLLRST   = 3'd0,
        ST_WAITLOCK = 3'd1,
        ST_STABLE   = 3'd2,
        ST_RELEASE  = 3'd3,
        ST_RUN      = 3'd4,
        ST_FAULT    = 3'd5,
        ST_BYPASS   = 3'd6
    } state_e;

    // One counter serves every phase, so it is sized for the longest one plus a spare bit.
    function automatic int cnt_width(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return $clog2(m) + 1;
    endfunction

endpackage

// File: rtl/cdc_sync2.sv
// rtl/cdc_sync2.sv - two-flop synchroniser for a single asynchronous level
module cdc_sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic sync_q;

    // Two back-to-back flops give the first one a full cycle to resolve metastability.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/pll_lock_supervisor.sv
// rtl/pll_lock_supervisor.sv - PLL reset/bypass sequencing, lock qualification and staggered reset release
module pll_lock_supervisor
    import hp2vga_clk_pkg::*;
#(
    parameter int PLL_RESET_CYCLES    = 16,
    parameter int LOCK_TIMEOUT_CYCLES = 65536,
    parameter int LOCK_STABLE_CYCLES  = 1024,
    parameter int MAX_RETRIES         = 3,
    parameter int NUM_CHANNELS        = 2,
    parameter int STAGGER_CYCLES      = 8
) (
    input  logic                    REFERENCECLK,
    input  logic                    RESET,
    input  logic                    LOCK,
    input  logic                    BYPASS_REQ,
    output logic                    PLL_RESETB,
    output logic                    PLL_BYPASS,
    output logic [NUM_CHANNELS-1:0] CHAN_RESETN,
    output logic                    READY,
    output logic                    FAULT,
    output logic [3:0]              RETRY_COUNT,
    output logic [7:0]              LOSS_COUNT,
    output logic [2:0]              STATE
);

    localparam int REL_CYCLES = NUM_CHANNELS * STAGGER_CYCLES;
    localparam int CW = cnt_width(PLL_RESET_CYCLES, LOCK_TIMEOUT_CYCLES, LOCK_STABLE_CYCLES, REL_CYCLES);
    localparam logic [CW-1:0] RST_LAST = CW'(PLL_RESET_CYCLES - 1);
    localparam logic [CW-1:0] TMO_LAST = CW'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0] STB_LAST = CW'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CW-1:0] REL_LAST = CW'(REL_CYCLES);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    logic lock_s;
    logic byp_s;
    logic byp_prev_q;
    logic byp_rise;

    state_e                  state_q, state_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [3:0]              retry_q, retry_d, retry_inc;
    logic [7:0]              loss_q, loss_d;
    logic                    pll_resetb_q, pll_resetb_d;
    logic                    pll_bypass_q, pll_bypass_d;
    logic [NUM_CHANNELS-1:0] chan_q, chan_d;
    logic                    ready_q, ready_d;
    logic                    fault_q, fault_d;

    cdc_sync2 u_sync_lock (.clk(REFERENCECLK), .rst_n(RESET), .d(LOCK),       .q(lock_s));
    cdc_sync2 u_sync_byp  (.clk(REFERENCECLK), .rst_n(RESET), .d(BYPASS_REQ), .q(byp_s));

    assign byp_rise = byp_s & ~byp_prev_q;

    // Next-state logic; outputs are derived from the next state so they register on the transition edge.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        retry_d   = retry_q;
        loss_d    = loss_q;
        retry_inc = (retry_q == 4'hF) ? retry_q : retry_q + 4'd1;

        if (byp_rise) begin
            state_d = ST_BYPASS;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_PLLRST: begin
                    if (cnt_q == RST_LAST) begin
                        state_d = ST_WAITLOCK;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                ST_WAITLOCK: begin
                    if (lock_s) begin
                        state_d = ST_STABLE;
                        cnt_d   = '0;
                    end else if (cnt_q == TMO_LAST) begin
                        retry_d = retry_inc;
                        cnt_d   = '0;
                        if ((MAX_RETRIES != 0) && (int'(retry_inc) >= MAX_RETRIES)) begin
                            state_d = ST_FAULT;
                        end else begin
                            state_d = ST_PLLRST;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                ST_STABLE: begin
                    if (!lock_s) begin
                        state_d = ST_WAITLOCK;
                        cnt_d   = '0;
                    end else if (cnt_q == STB_LAST) begin
                        state_d = ST_RELEASE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                ST_RELEASE: begin
                    if (!lock_s) begin
                        state_d = ST_PLLRST;
                        cnt_d   = '0;
                    end else if (cnt_q == REL_LAST) begin
                        state_d = ST_RUN;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                ST_RUN: begin
                    if (!lock_s) begin
                        loss_d  = (loss_q == 8'hFF) ? loss_q : loss_q + 8'd1;
                        state_d = ST_PLLRST;
                        cnt_d   = '0;
                    end
                end
                ST_FAULT: begin
                    state_d = ST_FAULT;
                end
                ST_BYPASS: begin
                    if (!byp_s) begin
                        state_d = ST_PLLRST;
                        cnt_d   = '0;
                        retry_d = 4'd0;
                    end else if (cnt_q != REL_LAST) begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                default: begin
                    state_d = ST_PLLRST;
                    cnt_d   = '0;
                end
            endcase
        end

        if (state_d == ST_RUN) retry_d = 4'd0;

        pll_resetb_d = (state_d == ST_WAITLOCK) || (state_d == ST_STABLE) ||
                       (state_d == ST_RELEASE)  || (state_d == ST_RUN);
        pll_bypass_d = (state_d == ST_BYPASS);
        fault_d      = (state_d == ST_FAULT);
        ready_d      = (state_d == ST_RUN) || ((state_d == ST_BYPASS) && (cnt_d == REL_LAST));

        chan_d = '0;
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            if ((state_d == ST_RELEASE) || (state_d == ST_BYPASS)) begin
                chan_d[i] = (cnt_d >= CW'((i + 1) * STAGGER_CYCLES));
            end else begin
                chan_d[i] = (state_d == ST_RUN);
            end
        end
    end

    // State, counter and registered outputs; reset forces the PLL and every channel into reset.
    always_ff @(posedge REFERENCECLK or negedge RESET) begin
        if (!RESET) begin
            state_q      <= ST_PLLRST;
            cnt_q        <= '0;
            retry_q      <= 4'd0;
            loss_q       <= 8'd0;
            pll_resetb_q <= 1'b0;
            pll_bypass_q <= 1'b0;
            chan_q       <= '0;
            ready_q      <= 1'b0;
            fault_q      <= 1'b0;
            byp_prev_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            retry_q      <= retry_d;
            loss_q       <= loss_d;
            pll_resetb_q <= pll_resetb_d;
            pll_bypass_q <= pll_bypass_d;
            chan_q       <= chan_d;
            ready_q      <= ready_d;
            fault_q      <= fault_d;
            byp_prev_q   <= byp_s;
        end
    end

    assign PLL_RESETB  = pll_resetb_q;
    assign PLL_BYPASS  = pll_bypass_q;
    assign CHAN_RESETN = chan_q;
    assign READY       = ready_q;
    assign FAULT       = fault_q;
    assign RETRY_COUNT = retry_q;
    assign LOSS_COUNT  = loss_q;
    assign STATE       = state_q;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// tb/tb_pll_lock_supervisor.sv - self-checking bench for pll_lock_supervisor
module tb_pll_lock_supervisor;

    localparam int P    = 4;
    localparam int T    = 32;
    localparam int S    = 8;
    localparam int MAXR = 2;
    localparam int N    = 3;
    localparam int ST   = 2;

    localparam int S_PLLRST = 0, S_WAIT = 1, S_STABLE = 2, S_RELEASE = 3,
                   S_RUN = 4, S_FAULT = 5, S_BYPASS = 6;

    logic       clk;
    logic       RESET;
    logic       LOCK;
    logic       BYPASS_REQ;
    logic       PLL_RESETB;
    logic       PLL_BYPASS;
    logic [2:0] CHAN_RESETN;
    logic       READY;
    logic       FAULT;
    logic [3:0] RETRY_COUNT;
    logic [7:0] LOSS_COUNT;
    logic [2:0] STATE;

    int n_checks = 0;
    int n_pass   = 0;
    int edge_n   = 0;

    pll_lock_supervisor #(
        .PLL_RESET_CYCLES(P), .LOCK_TIMEOUT_CYCLES(T), .LOCK_STABLE_CYCLES(S),
        .MAX_RETRIES(MAXR), .NUM_CHANNELS(N), .STAGGER_CYCLES(ST)
    ) dut (
        .REFERENCECLK(clk), .RESET(RESET), .LOCK(LOCK), .BYPASS_REQ(BYPASS_REQ),
        .PLL_RESETB(PLL_RESETB), .PLL_BYPASS(PLL_BYPASS), .CHAN_RESETN(CHAN_RESETN),
        .READY(READY), .FAULT(FAULT), .RETRY_COUNT(RETRY_COUNT),
        .LOSS_COUNT(LOSS_COUNT), .STATE(STATE)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int         at_edge;
        logic       lock_after;
        int         exp_state;
        logic       exp_resetb;
        logic [2:0] exp_chan;
        logic       exp_ready;
    } vec_t;

    vec_t vecs [15];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s at edge %0d: got %0d, expected %0d", name, edge_n, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        edge_n++;
    endtask

    task automatic step_to(input int n);
        while (edge_n < n) step();
    endtask

    // Hold reset for a few cycles, then release it 1 ns after a rising edge (edge 0).
    task automatic start(input logic lock_v, input logic byp_v);
        RESET = 1'b0;
        LOCK = 1'b0;
        BYPASS_REQ = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        LOCK = lock_v;
        BYPASS_REQ = byp_v;
        RESET = 1'b1;
        edge_n = 0;
    endtask

    // Schedule model: LOCK rising after edge d is first visible to the sequencer at edge d+3.
    // Attempt k listens for lock on edges base+1..base+T with base = P + k*(T+P).
    function automatic void model(input int d, output int e, output int a, output bit flt);
        int base;
        int s;
        flt = 1'b1;
        e   = -1;
        a   = MAXR;
        for (int k = 0; k < MAXR; k++) begin
            base = P + k * (T + P);
            s = (d + 3 > base + 1) ? d + 3 : base + 1;
            if (flt && s <= base + T) begin
                flt = 1'b0;
                e   = s;
                a   = k;
            end
        end
    endfunction

    initial begin
        RESET = 1'b0;
        LOCK = 1'b0;
        BYPASS_REQ = 1'b0;

        vecs[0]  = '{0,  1'b0, S_PLLRST,  1'b0, 3'b000, 1'b0};
        vecs[1]  = '{3,  1'b0, S_PLLRST,  1'b0, 3'b000, 1'b0};
        vecs[2]  = '{4,  1'b0, S_WAIT,    1'b1, 3'b000, 1'b0};
        vecs[3]  = '{10, 1'b1, S_WAIT,    1'b1, 3'b000, 1'b0};
        vecs[4]  = '{12, 1'b1, S_WAIT,    1'b1, 3'b000, 1'b0};
        vecs[5]  = '{13, 1'b1, S_STABLE,  1'b1, 3'b000, 1'b0};
        vecs[6]  = '{20, 1'b1, S_STABLE,  1'b1, 3'b000, 1'b0};
        vecs[7]  = '{21, 1'b1, S_RELEASE, 1'b1, 3'b000, 1'b0};
        vecs[8]  = '{22, 1'b1, S_RELEASE, 1'b1, 3'b000, 1'b0};
        vecs[9]  = '{23, 1'b1, S_RELEASE, 1'b1, 3'b001, 1'b0};
        vecs[10] = '{24, 1'b1, S_RELEASE, 1'b1, 3'b001, 1'b0};
        vecs[11] = '{25, 1'b1, S_RELEASE, 1'b1, 3'b011, 1'b0};
        vecs[12] = '{26, 1'b1, S_RELEASE, 1'b1, 3'b011, 1'b0};
        vecs[13] = '{27, 1'b1, S_RELEASE, 1'b1, 3'b111, 1'b0};
        vecs[14] = '{28, 1'b1, S_RUN,     1'b1, 3'b111, 1'b1};

        // Clean lock, driven from the vector table
        start(1'b0, 1'b0);
        check("rst_loss", LOSS_COUNT, 0);
        check("rst_fault", FAULT, 0);
        check("rst_bypass", PLL_BYPASS, 0);
        for (int i = 0; i < 15; i++) begin
            step_to(vecs[i].at_edge);
            check("clean_state", STATE, vecs[i].exp_state);
            check("clean_resetb", PLL_RESETB, vecs[i].exp_resetb);
            check("clean_chan", CHAN_RESETN, vecs[i].exp_chan);
            check("clean_ready", READY, vecs[i].exp_ready);
            LOCK = vecs[i].lock_after;
        end
        check("clean_retry", RETRY_COUNT, 0);

        // Run loss: one-cycle drop after edge 30, channels back in reset three edges later
        step_to(30);
        LOCK = 1'b0;
        step();
        LOCK = 1'b1;
        step_to(32);
        check("loss_chan_before", CHAN_RESETN, 7);
        check("loss_ready_before", READY, 1);
        step_to(33);
        check("loss_chan", CHAN_RESETN, 0);
        check("loss_ready", READY, 0);
        check("loss_count", LOSS_COUNT, 1);
        check("loss_state", STATE, S_PLLRST);
        step_to(37);
        check("reseq_wait", STATE, S_WAIT);
        step_to(38);
        check("reseq_stable", STATE, S_STABLE);
        step_to(52);
        check("reseq_ready_early", READY, 0);
        step_to(53);
        check("reseq_ready", READY, 1);
        check("reseq_loss", LOSS_COUNT, 1);

        // Second loss, then asynchronous reset while CHAN_RESETN is 011
        step_to(55);
        LOCK = 1'b0;
        step();
        LOCK = 1'b1;
        step_to(58);
        check("loss2_count", LOSS_COUNT, 2);
        step_to(75);
        check("mid_rel_chan", CHAN_RESETN, 3);
        check("mid_rel_state", STATE, S_RELEASE);
        #2;
        RESET = 1'b0;
        #1;
        check("async_state", STATE, S_PLLRST);
        check("async_resetb", PLL_RESETB, 0);
        check("async_bypass", PLL_BYPASS, 0);
        check("async_chan", CHAN_RESETN, 0);
        check("async_ready", READY, 0);
        check("async_fault", FAULT, 0);
        check("async_retry", RETRY_COUNT, 0);
        check("async_loss", LOSS_COUNT, 0);

        // Lock bounce during STABLE
        start(1'b0, 1'b0);
        step_to(10);
        LOCK = 1'b1;
        step_to(17);
        LOCK = 1'b0;
        step();
        LOCK = 1'b1;
        step_to(19);
        check("bounce_stable", STATE, S_STABLE);
        step_to(20);
        check("bounce_wait", STATE, S_WAIT);
        step_to(21);
        check("bounce_restable", STATE, S_STABLE);
        step_to(35);
        check("bounce_ready_early", READY, 0);
        step_to(36);
        check("bounce_ready", READY, 1);
        check("bounce_retry", RETRY_COUNT, 0);

        // Timeout to FAULT
        start(1'b0, 1'b0);
        step_to(35);
        check("tmo_wait", STATE, S_WAIT);
        step_to(36);
        check("tmo1_state", STATE, S_PLLRST);
        check("tmo1_retry", RETRY_COUNT, 1);
        step_to(40);
        check("tmo2_wait", STATE, S_WAIT);
        step_to(71);
        check("tmo2_prefault", FAULT, 0);
        step_to(72);
        check("fault_state", STATE, S_FAULT);
        check("fault_flag", FAULT, 1);
        check("fault_retry", RETRY_COUNT, 2);
        check("fault_resetb", PLL_RESETB, 0);
        step_to(150);
        check("fault_hold", STATE, S_FAULT);
        check("fault_hold_resetb", PLL_RESETB, 0);
        check("fault_hold_chan", CHAN_RESETN, 0);

        // Bypass requested during WAITLOCK with LOCK low
        start(1'b0, 1'b0);
        step_to(10);
        check("byp_pre", STATE, S_WAIT);
        BYPASS_REQ = 1'b1;
        step_to(12);
        check("byp_sync", STATE, S_WAIT);
        step_to(13);
        check("byp_state", STATE, S_BYPASS);
        check("byp_flag", PLL_BYPASS, 1);
        check("byp_resetb", PLL_RESETB, 0);
        check("byp_chan0", CHAN_RESETN, 0);
        step_to(15);
        check("byp_chan1", CHAN_RESETN, 1);
        step_to(17);
        check("byp_chan3", CHAN_RESETN, 3);
        step_to(18);
        check("byp_ready_early", READY, 0);
        step_to(19);
        check("byp_chan7", CHAN_RESETN, 7);
        check("byp_ready", READY, 1);
        step_to(25);
        check("byp_hold_ready", READY, 1);
        check("byp_hold_state", STATE, S_BYPASS);
        BYPASS_REQ = 1'b0;
        step_to(27);
        check("byp_exit_sync", STATE, S_BYPASS);
        step_to(28);
        check("byp_exit_state", STATE, S_PLLRST);
        check("byp_exit_flag", PLL_BYPASS, 0);
        check("byp_exit_chan", CHAN_RESETN, 0);
        check("byp_exit_ready", READY, 0);
        check("byp_exit_retry", RETRY_COUNT, 0);

        // Randomised lock arrival time against the schedule model
        for (int it = 0; it < 12; it++) begin
            int  d, e, a;
            bit  flt;
            int  got_ready, got_fault, got_chan2, retry_e, retry_f;
            d = $urandom_range(0, 80);
            model(d, e, a, flt);
            got_ready = -1;
            got_fault = -1;
            got_chan2 = -1;
            retry_e   = -1;
            retry_f   = -1;
            start(d == 0, 1'b0);
            while (edge_n < 110) begin
                step();
                if (edge_n == d) LOCK = 1'b1;
                if (READY && got_ready < 0) got_ready = edge_n;
                if (FAULT && got_fault < 0) begin
                    got_fault = edge_n;
                    retry_f   = RETRY_COUNT;
                end
                if (CHAN_RESETN[2] && got_chan2 < 0) got_chan2 = edge_n;
                if (edge_n == e) retry_e = RETRY_COUNT;
            end
            if (!flt) begin
                check("rnd_ready_edge", got_ready, e + S + N * ST + 1);
                check("rnd_chan2_edge", got_chan2, e + S + N * ST);
                check("rnd_retry", retry_e, a);
                check("rnd_no_fault", got_fault, -1);
            end else begin
                check("rnd_fault_edge", got_fault, MAXR * (T + P));
                check("rnd_fault_retry", retry_f, MAXR);
                check("rnd_no_ready", got_ready, -1);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
